// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side write strobe, host read handshake and
// status outputs of the UART receive FIFO, bundled for port connection.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 RxReady;
    logic [DATA_BITS-1:0] RxData;
    logic                 ReadEn;
    logic                 ClearOverrun;
    logic [DATA_BITS-1:0] ReadData;
    logic                 ReadValid;
    logic                 Empty;
    logic                 Full;
    logic                 AlmostFull;
    logic [CW-1:0]        Count;
    logic                 Overrun;

    // Host / receiver side: drives strobes, observes data and status
    modport master (
        output RxReady, RxData, ReadEn, ClearOverrun,
        input  ReadData, ReadValid, Empty, Full, AlmostFull, Count, Overrun
    );

    // FIFO side
    modport slave (
        input  RxReady, RxData, ReadEn, ClearOverrun,
        output ReadData, ReadValid, Empty, Full, AlmostFull, Count, Overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte buffer behind the UART receiver. Captures every
// RxReady strobe while not full, drops (and flags Overrun) while full,
// and hands bytes to the host through ReadEn.
// Optional macro UART_RX_FIFO_FWFT_EN selects first-word fall-through
// output; when undefined the read data is registered (1-cycle latency).
module uart_rx_fifo #(
    parameter int DATA_BITS         = 8,
    parameter int DEPTH             = 16,
    parameter int ALMOST_FULL_LEVEL = 12
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [CW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 overrun_q, overrun_d;

    logic                 empty, full, almost_full;
    logic                 wr_acc, rd_acc, wr_drop;
    logic [AW-1:0]        wr_idx, rd_idx;

    // Status flags come only from registered count; accept decisions use them
    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == CW'(DEPTH));
        almost_full = (count_q >= CW'(ALMOST_FULL_LEVEL));
        wr_acc      = bus.RxReady && !full;
        wr_drop     = bus.RxReady && full;   // a same-cycle pop does not rescue it
        rd_acc      = bus.ReadEn && !empty;  // no bypass when empty
        wr_idx      = wr_ptr_q[AW-1:0];
        rd_idx      = rd_ptr_q[AW-1:0];
    end

    // Next-state for pointers, occupancy and the sticky overrun flag
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + CW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + CW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // set wins over clear
        if (wr_drop)               overrun_d = 1'b1;
        else if (bus.ClearOverrun) overrun_d = 1'b0;
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage array; cleared on reset so no stale byte survives it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_acc) begin
            mem_q[wr_idx] <= bus.RxData;
        end
    end

`ifdef UART_RX_FIFO_FWFT_EN
    // Head entry is presented directly; ReadEn acknowledges and pops it
    always_comb begin
        bus.ReadData  = mem_q[rd_idx];
        bus.ReadValid = !empty;
    end
`else
    logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;

    // Registered read: popped byte held until the next pop, valid for one cycle
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc;
        if (rd_acc) rd_data_d = mem_q[rd_idx];
    end

    // Read output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Drive registered read outputs
    always_comb begin
        bus.ReadData  = rd_data_q;
        bus.ReadValid = rd_valid_q;
    end
`endif

    // Drive status outputs
    always_comb begin
        bus.Empty      = empty;
        bus.Full       = full;
        bus.AlmostFull = almost_full;
        bus.Count      = count_q;
        bus.Overrun    = overrun_q;
    end
endmodule
